// File: rtl/nes_cpu_pkg.sv
// rtl/nes_cpu_pkg.sv - shared CPU-subsystem types and constants (sprite DMA state, register addresses)
package nes_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

  localparam logic [15:0] OAM_DMA_REG   = 16'h4014;
  localparam logic [2:0]  PPU_OAMDATA   = 3'd4;
  localparam int          OAM_DMA_BYTES = 256;

  function automatic logic [15:0] oam_src_addr(input logic [7:0] page, input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: halts the CPU and copies one WRAM page into OAM via OAMDATA
// Optional OAM_DMA_ODD_ALIGN_EN inserts an ALIGN cycle when HALT lands on an odd cycle.
module oam_dma
  import nes_cpu_pkg::*;
#(
  parameter logic [15:0] PAGE_REG_ADDR = OAM_DMA_REG,
  parameter logic [2:0]  OAMDATA_SEL   = PPU_OAMDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_we,
  input  logic [7:0]  mem_data_in,
  output logic        cpu_rdy,
  output logic        dma_bus_sel,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic        ppu_reg_cs,
  output logic [2:0]  ppu_reg_addr,
  output logic        ppu_we,
  output logic [7:0]  ppu_data_out,
  output logic        busy
);

  oam_dma_state_t state;
  logic [7:0]     page;
  logic [7:0]     idx;
  logic           trigger;
  logic           last_byte;

  assign trigger   = cpu_we && (cpu_addr == PAGE_REG_ADDR);
  assign last_byte = (idx == 8'(OAM_DMA_BYTES - 1));

  assign dma_we = 1'b0;
  // WRAM read data arrives the cycle after READ, so it is forwarded straight through in WRITE.
  assign ppu_data_out = (state == WRITE) ? mem_data_in : 8'h00;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic cyc_odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_odd <= 1'b0;
    end else begin
      cyc_odd <= ~cyc_odd;
    end
  end
`endif

  // Outputs are loaded alongside the state they belong to, so they are glitch-free registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      page         <= 8'h00;
      idx          <= 8'h00;
      cpu_rdy      <= 1'b1;
      busy         <= 1'b0;
      dma_bus_sel  <= 1'b0;
      dma_addr     <= 16'h0000;
      ppu_reg_cs   <= 1'b1;
      ppu_reg_addr <= 3'd0;
      ppu_we       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            page    <= cpu_data;
            idx     <= 8'h00;
            state   <= HALT;
            cpu_rdy <= 1'b0;
            busy    <= 1'b1;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          if (cyc_odd) begin
            state <= ALIGN;
          end else begin
            state       <= READ;
            dma_bus_sel <= 1'b1;
            dma_addr    <= oam_src_addr(page, idx);
          end
`else
          state       <= READ;
          dma_bus_sel <= 1'b1;
          dma_addr    <= oam_src_addr(page, idx);
`endif
        end
        ALIGN: begin
          state       <= READ;
          dma_bus_sel <= 1'b1;
          dma_addr    <= oam_src_addr(page, idx);
        end
        READ: begin
          state        <= WRITE;
          dma_addr     <= 16'h0000;
          ppu_reg_cs   <= 1'b0;
          ppu_reg_addr <= OAMDATA_SEL;
          ppu_we       <= 1'b1;
        end
        WRITE: begin
          idx          <= idx + 8'd1;
          ppu_reg_cs   <= 1'b1;
          ppu_reg_addr <= 3'd0;
          ppu_we       <= 1'b0;
          if (last_byte) begin
            state       <= IDLE;
            cpu_rdy     <= 1'b1;
            busy        <= 1'b0;
            dma_bus_sel <= 1'b0;
          end else begin
            state    <= READ;
            dma_addr <= oam_src_addr(page, idx + 8'd1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - randomized self-checking bench for oam_dma against a page-copy reference model
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  mem_data_in = 8'h00;
  logic        cpu_rdy;
  logic        dma_bus_sel;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic        ppu_we;
  logic [7:0]  ppu_data_out;
  logic        busy;

  oam_dma dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cpu_we       (cpu_we),
    .mem_data_in  (mem_data_in),
    .cpu_rdy      (cpu_rdy),
    .dma_bus_sel  (dma_bus_sel),
    .dma_addr     (dma_addr),
    .dma_we       (dma_we),
    .ppu_reg_cs   (ppu_reg_cs),
    .ppu_reg_addr (ppu_reg_addr),
    .ppu_we       (ppu_we),
    .ppu_data_out (ppu_data_out),
    .busy         (busy)
  );

  logic [7:0]  wram [0:65535];
  logic [15:0] rd_addr [0:255];
  logic [7:0]  wr_data [0:255];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          bad_busy;
  int          bad_ppu;

  always #5 clk = ~clk;

  // Synchronous-read WRAM and a cycle counter since reset (cycle parity for alignment).
  always @(posedge clk) begin
    mem_data_in <= wram[dma_addr];
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {31'd0, cpu_rdy, busy, dma_bus_sel, dma_addr, dma_we, ppu_reg_cs, ppu_reg_addr, ppu_we, ppu_data_out},
          {31'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00});
  endtask

  task automatic run_dma(input logic [7:0] pg, input bit inject, input int reset_at,
                         output int halt, output int nw, output int nr, output bit par);
    cpu_addr = 16'h4014;
    cpu_data = pg;
    cpu_we   = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    par = cyc[0];
    check("rdy_fall", {63'd0, cpu_rdy}, 64'd0);
    halt = 0; nw = 0; nr = 0; bad_busy = 0; bad_ppu = 0;
    for (int c = 0; c < 700; c++) begin
      if (cpu_rdy) break;
      halt++;
      if (busy !== 1'b1) bad_busy++;
      if (dma_bus_sel && !ppu_we) begin
        if (nr < 256) rd_addr[nr] = dma_addr;
        nr++;
      end
      if (ppu_we) begin
        if (ppu_reg_cs !== 1'b0 || ppu_reg_addr !== 3'd4 || dma_bus_sel !== 1'b1 || dma_we !== 1'b0) bad_ppu++;
        if (nw < 256) wr_data[nw] = ppu_data_out;
        nw++;
      end
      cpu_we   = inject && (nw == 50);
      cpu_addr = 16'h4014;
      cpu_data = 8'h05;
      if (reset_at >= 0 && nw == reset_at) reset = 1'b1;
      @(negedge clk);
    end
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
  endtask

  // Reference: 256 reads of {pg,i} in order, each byte written to OAMDATA, 513 halt cycles
  // plus one when alignment is built in and HALT fell on an odd cycle.
  task automatic verify(input string tag, input logic [7:0] pg, input int halt, input int nw,
                        input int nr, input bit par);
    int exp_halt;
    int bad_a;
    int bad_d;
    exp_halt = 513;
`ifdef OAM_DMA_ODD_ALIGN_EN
    if (par) exp_halt = 514;
`endif
    bad_a = 0;
    bad_d = 0;
    for (int i = 0; i < 256; i++) begin
      if (rd_addr[i] !== {pg, 8'(i)}) bad_a++;
      if (wr_data[i] !== wram[{pg, 8'(i)}]) bad_d++;
    end
    check({tag, "_halt"}, 64'(halt), 64'(exp_halt));
    check({tag, "_nreads"}, 64'(nr), 64'd256);
    check({tag, "_nwrites"}, 64'(nw), 64'd256);
    check({tag, "_addr_seq"}, 64'(bad_a), 64'd0);
    check({tag, "_data_seq"}, 64'(bad_d), 64'd0);
    check({tag, "_busy"}, 64'(bad_busy), 64'd0);
    check({tag, "_ppu_strobe"}, 64'(bad_ppu), 64'd0);
    check_idle({tag, "_done"});
  endtask

  initial begin
    int  halt;
    int  nw;
    int  nr;
    bit  par;
    logic [7:0] pg;

    for (int a = 0; a < 65536; a++) wram[a] = 8'($urandom);

    @(negedge clk);
    @(negedge clk);
    check_idle("reset");

    // Trigger coinciding with reset is dropped.
    cpu_addr = 16'h4014; cpu_data = 8'h02; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    check("trig_in_reset_rdy", {63'd0, cpu_rdy}, 64'd1);

    // Neighbouring addresses must not start a transfer.
    cpu_addr = 16'h4013; cpu_data = 8'h02; cpu_we = 1'b1;
    @(negedge clk);
    cpu_addr = 16'h4015;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    @(negedge clk);
    check("near_addr_rdy", {62'd0, cpu_rdy, busy}, 64'd2);
    @(negedge clk);
    check("near_addr_idle", {62'd0, cpu_rdy, busy}, 64'd2);

    run_dma(8'h02, 1'b0, -1, halt, nw, nr, par);
    verify("page02", 8'h02, halt, nw, nr, par);

    run_dma(8'hFF, 1'b0, -1, halt, nw, nr, par);
    verify("pageFF", 8'hFF, halt, nw, nr, par);

    @(negedge clk);
    run_dma(8'h00, 1'b0, -1, halt, nw, nr, par);
    verify("page00", 8'h00, halt, nw, nr, par);

    run_dma(8'h03, 1'b1, -1, halt, nw, nr, par);
    verify("inject", 8'h03, halt, nw, nr, par);
    repeat (2) @(negedge clk);
    check("inject_no_restart", {63'd0, cpu_rdy}, 64'd1);

    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pg = 8'($urandom);
      run_dma(pg, 1'b0, -1, halt, nw, nr, par);
      verify($sformatf("rand%0d", t), pg, halt, nw, nr, par);
    end

    pg = 8'($urandom);
    run_dma(pg, 1'b0, 100, halt, nw, nr, par);
    check("reset_mid_writes", 64'(nw), 64'd100);
    check_idle("reset_mid_outputs");
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_release");

    pg = 8'($urandom);
    run_dma(pg, 1'b0, -1, halt, nw, nr, par);
    verify("after_reset", pg, halt, nw, nr, par);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
